// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin shared double-dabble binary-to-BCD converter, one shift per cycle.
// Optional BCD_LEADING_BLANK_EN replaces leading zero digits with blank code 4'hB.
module bcd_conv_scheduler #(
    parameter int WIDTH = 13,
    parameter int ITER  = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] bin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] bin1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             src,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] op_q;
    logic [3:0]       cnt_q;
    logic [15:0]      dig_q, out_q, adj, nxt, out_d;
    logic             grant_q, last_q, src_q, ack0_q, ack1_q, done_q, g;
    always_comb begin
        g = (req0 && req1) ? ~last_q : req1;
        adj = dig_q;
        for (int i = 0; i < 4; i++)
            adj[i*4 +: 4] = dig_q[i*4 +: 4] >= 4'd5 ? dig_q[i*4 +: 4] + 4'd3 : dig_q[i*4 +: 4];
        nxt = {adj[14:0], op_q[cnt_q]};
`ifdef BCD_LEADING_BLANK_EN
        out_d[15:12] = nxt[15:12] == 4'd0 ? 4'hB : nxt[15:12];
        out_d[11:8]  = nxt[15:8] == 8'd0 ? 4'hB : nxt[11:8];
        out_d[7:4]   = nxt[15:4] == 12'd0 ? 4'hB : nxt[7:4];
        out_d[3:0]   = nxt[3:0];
`else
        out_d = nxt;
`endif
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            out_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            src_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (req0 || req1) begin
                    grant_q <= g;
                    last_q  <= g;
                    op_q    <= g ? bin1 : bin0;
                    dig_q   <= '0;
                    cnt_q   <= 4'(ITER - 1);
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    dig_q <= nxt;
                    cnt_q <= cnt_q - 4'd1;
                    // Final iteration goes straight to the display registers so digits never show partial values
                    if (cnt_q == 4'd0) begin
                        out_q   <= out_d;
                        src_q   <= grant_q;
                        ack0_q  <= ~grant_q;
                        ack1_q  <= grant_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign src       = src_q;
    assign thousands = out_q[15:12];
    assign hundreds  = out_q[11:8];
    assign tens      = out_q[7:4];
    assign ones      = out_q[3:0];
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: directed self-checking bench for bcd_conv_scheduler.
module tb_bcd_conv_scheduler;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [12:0] bin0 = '0, bin1 = '0;
    logic        ack0, ack1, busy, done, src;
    logic [3:0]  thousands, hundreds, tens, ones;
    int          errors = 0, checks = 0;
    wire  [15:0] dig = {thousands, hundreds, tens, ones};
    localparam logic [15:0] E8191 = 16'h8191, E1234 = 16'h1234, E4321 = 16'h4321;
`ifdef BCD_LEADING_BLANK_EN
    localparam logic [15:0] E56 = 16'hBB56, E7 = 16'hBBB7, E999 = 16'hB999;
    localparam logic [15:0] E10 = 16'hBB10, E0 = 16'hBBB0, E305 = 16'hB305;
`else
    localparam logic [15:0] E56 = 16'h0056, E7 = 16'h0007, E999 = 16'h0999;
    localparam logic [15:0] E10 = 16'h0010, E0 = 16'h0000, E305 = 16'h0305;
`endif
    bcd_conv_scheduler dut (
        .clock(clock), .reset(reset), .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done), .src(src),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones)
    );
    always #5 clock = ~clock;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    // Called just after the acceptance edge; follows the conversion up to its done cycle.
    task automatic conv(input string tag, input logic ex_src, input logic [15:0] ex_dig, input logic [15:0] prior);
        int n, nb;
        logic held;
        n = 0;
        nb = int'(busy);
        held = 1'b1;
        while (!done && n < 40) begin
            if (dig !== prior) held = 1'b0;
            tick;
            n++;
            nb += int'(busy);
        end
        check({tag, " done"}, done, 1);
        check({tag, " latency"}, n, 13);
        check({tag, " busy_cycles"}, nb, 14);
        check({tag, " held"}, held, 1);
        check({tag, " digits"}, dig, ex_dig);
        check({tag, " src"}, src, ex_src);
        check({tag, " ack0"}, ack0, !ex_src);
        check({tag, " ack1"}, ack1, ex_src);
    endtask
    task automatic do_reset;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick;
    endtask
    initial begin
        int spurious;
        repeat (2) @(posedge clock);
        #1;
        check("rst digits", dig, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst acks", {ack0, ack1}, 0);
        check("rst src", src, 0);
        reset = 1'b0;
        req0 = 1'b1; bin0 = 13'd8191;
        tick;
        check("t1 busy_accept", busy, 1);
        conv("t1", 1'b0, E8191, 16'h0000);
        req0 = 1'b0;
        tick;
        check("t1 idle", busy, 0);
        do_reset;
        req0 = 1'b1; req1 = 1'b1; bin0 = 13'd1234; bin1 = 13'd56;
        tick;
        conv("t2a", 1'b0, E1234, 16'h0000);
        req0 = 1'b0;
        tick;
        check("t2 no_reaccept_in_done", busy, 0);
        tick;
        check("t2 accept_e15", busy, 1);
        conv("t2b", 1'b1, E56, E1234);
        req1 = 1'b0;
        tick;
        req0 = 1'b1; req1 = 1'b1; bin0 = 13'd4321; bin1 = 13'd7;
        for (int k = 0; k < 4; k++) begin
            tick;
            conv($sformatf("t3_%0d", k), 1'(k % 2), (k % 2) ? E7 : E4321, (k == 0) ? E56 : ((k % 2) ? E4321 : E7));
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            tick;
        end
        req1 = 1'b1; bin1 = 13'd999;
        tick;
        bin1 = 13'd4000;
        req1 = 1'b0;
        conv("t4", 1'b1, E999, E7);
        tick;
        req0 = 1'b1; bin0 = 13'd77;
        tick;
        repeat (5) tick;
        #2 reset = 1'b1;
        #1;
        check("t5 rst digits", dig, 0);
        check("t5 rst src", src, 0);
        check("t5 rst busy", busy, 0);
        check("t5 rst done_ack", {done, ack0, ack1}, 0);
        #1 reset = 1'b0;
        req0 = 1'b0;
        spurious = 0;
        repeat (20) begin
            tick;
            if (done || ack0 || ack1 || busy) spurious++;
        end
        check("t5 no_ack", spurious, 0);
        req0 = 1'b1; bin0 = 13'd10;
        tick;
        req0 = 1'b0;
        conv("t5", 1'b0, E10, 16'h0000);
        tick;
        req0 = 1'b1; bin0 = 13'd0;
        tick;
        req0 = 1'b0;
        conv("t6 zero", 1'b0, E0, E10);
        tick;
        req0 = 1'b1; bin0 = 13'd305;
        tick;
        req0 = 1'b0;
        conv("t6 305", 1'b0, E305, E0);
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
